// File: rtl/dmem_imem_arbiter_pkg.sv
// Shared RV32I type definitions: load/store funct3 encodings and the
// memory-port arbiter state type.
package rv32i_types;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } arb_state_t;

endpackage

// File: rtl/dmem_imem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM
// stage; data has priority, bounded by a starvation counter for fetch.
module dmem_imem_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic [31:0] i_rdata,
   output logic        i_resp,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byte_enable,
   output logic [31:0] d_rdata,
   output logic        d_resp,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   arb_state_t  state, state_nx;
   logic [3:0]  starve_cnt, starve_nx;
   logic        mem_read_nx, mem_write_nx;
   logic [31:0] mem_address_nx, mem_wdata_nx;
   logic [3:0]  mem_byte_enable_nx;
   logic        d_req, d_win;

   always_comb begin
      state_nx           = state;
      starve_nx          = starve_cnt;
      mem_read_nx        = mem_read;
      mem_write_nx       = mem_write;
      mem_address_nx     = mem_address;
      mem_wdata_nx       = mem_wdata;
      mem_byte_enable_nx = mem_byte_enable;
      d_req              = d_read | d_write;
      d_win              = d_req && (!i_read || (starve_cnt < LIMIT));

      case (state)
         IDLE: begin
            if (d_win) begin
               state_nx           = D_BUSY;
               mem_write_nx       = d_write;
               mem_read_nx        = d_read & ~d_write;
               mem_address_nx     = d_address;
               mem_wdata_nx       = d_wdata;
               mem_byte_enable_nx = d_write ? d_byte_enable : '1;
               // Only grants that overtake a waiting fetch count toward starvation.
               if (!i_read)
                  starve_nx = '0;
               else if (starve_cnt != 4'hF)
                  starve_nx = starve_cnt + 4'd1;
            end else if (i_read) begin
               state_nx           = I_BUSY;
               mem_read_nx        = 1'b1;
               mem_write_nx       = 1'b0;
               mem_address_nx     = i_address;
               mem_wdata_nx       = '0;
               mem_byte_enable_nx = '1;
               starve_nx          = '0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_resp) begin
               state_nx     = IDLE;
               mem_read_nx  = 1'b0;
               mem_write_nx = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         starve_cnt      <= '0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_wdata       <= '0;
         mem_byte_enable <= '0;
      end else begin
         state           <= state_nx;
         starve_cnt      <= starve_nx;
         mem_read        <= mem_read_nx;
         mem_write       <= mem_write_nx;
         mem_address     <= mem_address_nx;
         mem_wdata       <= mem_wdata_nx;
         mem_byte_enable <= mem_byte_enable_nx;
      end
   end

   assign i_resp  = (state == I_BUSY) && mem_resp;
   assign d_resp  = (state == D_BUSY) && mem_resp;
   assign i_rdata = i_resp ? mem_rdata : '0;
   assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_imem_arbiter.sv
// Directed bench for dmem_imem_arbiter: a transaction-level model checked
// every cycle, plus literal expectations for each scenario.
module tb_dmem_imem_arbiter;

   localparam int LIM = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_read = 1'b0;
   logic [31:0] i_address = '0;
   logic [31:0] i_rdata;
   logic        i_resp;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_address = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_byte_enable = '0;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;

   int total = 0;
   int bad   = 0;

   dmem_imem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: owner of the port (0 none, 1 fetch, 2 data), the latched request,
   // and a log of every grant in order.
   int          owner = 0;
   int          starve = 0;
   bit          live = 1'b0;
   logic        e_rd = 1'b0, e_wr = 1'b0;
   logic [31:0] e_addr = '0, e_wdata = '0;
   logic [3:0]  e_be = '0;
   int          grants[$];

   always @(posedge clk) begin
      if (rst) begin
         owner = 0; starve = 0; live = 1'b1;
         e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_be = 0;
      end else if (owner == 0) begin
         if ((d_read || d_write) && (!i_read || starve < LIM)) begin
            owner = 2;
            grants.push_back(2);
            e_wr = d_write; e_rd = !d_write;
            e_addr = d_address; e_wdata = d_wdata;
            e_be = d_write ? d_byte_enable : 4'hF;
            starve = i_read ? ((starve < 15) ? starve + 1 : 15) : 0;
         end else if (i_read) begin
            owner = 1;
            grants.push_back(1);
            e_rd = 1; e_wr = 0; e_addr = i_address; e_wdata = 0; e_be = 4'hF;
            starve = 0;
         end
      end else if (mem_resp) begin
         owner = 0; e_rd = 0; e_wr = 0;
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("mem_read",  {31'b0, mem_read},  {31'b0, e_rd});
         chk("mem_write", {31'b0, mem_write}, {31'b0, e_wr});
         chk("mem_address", mem_address, e_addr);
         chk("mem_wdata", mem_wdata, e_wdata);
         chk("mem_be", {28'b0, mem_byte_enable}, {28'b0, e_be});
         chk("i_resp", {31'b0, i_resp}, {31'b0, !rst && owner == 1 && mem_resp});
         chk("d_resp", {31'b0, d_resp}, {31'b0, !rst && owner == 2 && mem_resp});
         chk("i_rdata", i_rdata, (!rst && owner == 1 && mem_resp) ? mem_rdata : 32'h0);
         chk("d_rdata", d_rdata, (!rst && owner == 2 && mem_resp) ? mem_rdata : 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic respond(input logic [31:0] data);
      mem_resp  = 1'b1;
      mem_rdata = data;
      #1;
   endtask

   task automatic release_resp();
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   int base;
   int obs[6];
   int exp_order[6] = '{2, 2, 1, 2, 2, 1};

   initial begin
      // Reset while a fetch is already requested.
      i_read = 1'b1; i_address = 32'h40;
      step(); step();
      chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
      chk("rst_mem_address", mem_address, 32'h0);
      chk("rst_mem_be", {28'b0, mem_byte_enable}, 32'h0);
      chk("rst_i_resp", {31'b0, i_resp}, 32'h0);
      rst = 1'b0;
      step();
      chk("rst_first_strobe", {31'b0, mem_read}, 32'h1);
      chk("rst_first_addr", mem_address, 32'h40);
      respond(32'h1234_5678);
      step(); release_resp(); i_read = 1'b0;

      // Single fetch.
      i_read = 1'b1; i_address = 32'h60;
      step();
      chk("fetch_strobe", {31'b0, mem_read}, 32'h1);
      chk("fetch_addr", mem_address, 32'h60);
      respond(32'h00A0_0093);
      chk("fetch_i_resp", {31'b0, i_resp}, 32'h1);
      chk("fetch_i_rdata", i_rdata, 32'h00A0_0093);
      chk("fetch_d_resp", {31'b0, d_resp}, 32'h0);
      step(); release_resp(); i_read = 1'b0;
      step();

      // Byte store; data change while busy must not leak through.
      d_write = 1'b1; d_address = 32'h1000; d_wdata = 32'h00AB_0000; d_byte_enable = 4'b0100;
      step();
      chk("store_write", {31'b0, mem_write}, 32'h1);
      chk("store_read", {31'b0, mem_read}, 32'h0);
      chk("store_addr", mem_address, 32'h1000);
      chk("store_be", {28'b0, mem_byte_enable}, 32'h4);
      d_wdata = 32'hFFFF_FFFF;
      step();
      chk("store_wdata_held", mem_wdata, 32'h00AB_0000);
      respond(32'h0);
      chk("store_d_resp", {31'b0, d_resp}, 32'h1);
      step(); release_resp(); d_write = 1'b0;
      step();

      // Contention: data first, fetch strobe two cycles after data response.
      i_read = 1'b1; i_address = 32'h80;
      d_read = 1'b1; d_address = 32'h2000;
      step();
      chk("cont_d_first", mem_address, 32'h2000);
      chk("cont_d_load_be", {28'b0, mem_byte_enable}, 32'hF);
      step();
      respond(32'hCAFE_0001);
      chk("cont_d_rdata", d_rdata, 32'hCAFE_0001);
      chk("cont_i_quiet", {31'b0, i_resp}, 32'h0);
      step(); release_resp(); d_read = 1'b0;
      chk("cont_bubble", {31'b0, mem_read}, 32'h0);
      step();
      chk("cont_i_strobe", {31'b0, mem_read}, 32'h1);
      chk("cont_i_addr", mem_address, 32'h80);
      respond(32'h0);
      step(); release_resp(); i_read = 1'b0;
      step();

      // Starvation with both requesters held high.
      base = grants.size();
      i_read = 1'b1; i_address = 32'h100;
      d_read = 1'b1; d_address = 32'h3000;
      for (int k = 0; k < 6; k++) begin
         step();
         obs[k] = (mem_address == 32'h100) ? 1 : (mem_address == 32'h3000) ? 2 : 0;
         respond(32'h0);
         step(); release_resp();
      end
      i_read = 1'b0; d_read = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("starve_dut_%0d", k), obs[k], exp_order[k]);
         chk($sformatf("starve_model_%0d", k),
             (grants.size() > base + k) ? grants[base + k] : -1, exp_order[k]);
      end
      step();

      // Stray response in IDLE.
      respond(32'hDEAD_BEEF);
      chk("stray_i_resp", {31'b0, i_resp}, 32'h0);
      chk("stray_d_resp", {31'b0, d_resp}, 32'h0);
      chk("stray_d_rdata", d_rdata, 32'h0);
      step(); release_resp();
      chk("stray_no_strobe", {31'b0, mem_read | mem_write}, 32'h0);

      // Reset during a data transaction.
      d_write = 1'b1; d_address = 32'h4000; d_wdata = 32'h55; d_byte_enable = 4'b0001;
      step();
      chk("rstbusy_write", {31'b0, mem_write}, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0; d_write = 1'b0;
      chk("rstbusy_cleared", {31'b0, mem_write}, 32'h0);
      respond(32'h77);
      chk("rstbusy_no_d_resp", {31'b0, d_resp}, 32'h0);
      step(); release_resp();
      step();
      chk("rstbusy_idle", {31'b0, mem_read | mem_write}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
